// File: rtl/kf6845_vertical_address.sv
// kf6845_vertical_address: vertical timing and refresh-address generator of the KF6845 CRTC.
module kf6845_vertical_address (
    input  logic        clock,
    input  logic        reset,
    input  logic        video_clock_enable,
    input  logic [7:0]  internal_data_bus_in,
    input  logic        write_vertical_total_register,
    input  logic        write_vertical_total_adjust_register,
    input  logic        write_vertical_displayed_register,
    input  logic        write_vsync_position_register,
    input  logic        write_max_scan_line_register,
    input  logic        write_start_address_h_register,
    input  logic        write_start_address_l_register,
    input  logic        h_display_end,
    input  logic        line_end,
    output logic [13:0] MA,
    output logic [4:0]  RA,
    output logic        V_total,
    output logic        VSYNC,
    output logic        v_display
);
    typedef enum logic {NORMAL, ADJUST} state_t;

    state_t      state, state_n;
    logic [6:0]  r4, r6, r7, row, row_n;
    logic [4:0]  r5, r9, ra, ra_n, adj, adj_n, ra_out_n;
    logic [13:0] sa, row_start, row_start_n, next_row_start, next_row_start_n, ma_n;
    logic [3:0]  vcnt, vcnt_n;
    logic        le, hde, row_end, last_row, frame_end, to_adjust, capture, new_row, vsync_set;
    logic        vsync_n, v_display_n, v_total_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r4 <= '0;
            r5 <= '0;
            r6 <= '0;
            r7 <= '0;
            r9 <= '0;
            sa <= '0;
        end else begin
            if (write_vertical_total_register)        r4 <= internal_data_bus_in[6:0];
            if (write_vertical_total_adjust_register) r5 <= internal_data_bus_in[4:0];
            if (write_vertical_displayed_register)    r6 <= internal_data_bus_in[6:0];
            if (write_vsync_position_register)        r7 <= internal_data_bus_in[6:0];
            if (write_max_scan_line_register)         r9 <= internal_data_bus_in[4:0];
            if (write_start_address_h_register)       sa[13:8] <= internal_data_bus_in[5:0];
            if (write_start_address_l_register)       sa[7:0] <= internal_data_bus_in;
        end
    end

    always_comb begin
        le               = video_clock_enable & line_end;
        hde              = video_clock_enable & h_display_end;
        row_end          = (state == NORMAL) && le && (ra >= r9);
        last_row         = row >= r4;
        frame_end        = (row_end && last_row && r5 == 5'd0) ||
                           ((state == ADJUST) && le && ({1'b0, adj} + 6'd1 >= {1'b0, r5}));
        to_adjust        = row_end && last_row && r5 != 5'd0;
        // Same-cycle h_display_end and line_end: the live MA feeds the new row start.
        capture          = hde && (state == NORMAL) && (ra >= r9);
        next_row_start_n = capture ? MA : next_row_start;
        state_n          = frame_end ? NORMAL : to_adjust ? ADJUST : state;
        row_n            = frame_end ? '0 : (row_end && !last_row) ? row + 7'd1 : row;
        ra_n             = (frame_end || row_end) ? '0 : ((state == NORMAL) && le) ? ra + 5'd1 : ra;
        adj_n            = to_adjust ? '0 : ((state == ADJUST) && le && !frame_end) ? adj + 5'd1 : adj;
        row_start_n      = frame_end ? sa : row_end ? next_row_start_n : row_start;
        ma_n             = frame_end ? sa : row_end ? next_row_start_n : le ? row_start :
                           video_clock_enable ? MA + 14'd1 : MA;
        ra_out_n         = (state_n == NORMAL) ? ra_n : adj_n;
        new_row          = frame_end || (row_end && !last_row);
        vsync_set        = new_row && (row_n == r7) && (r7 <= r4);
        vsync_n          = vsync_set || (VSYNC && !(le && vcnt == 4'd15));
        vcnt_n           = vsync_set ? '0 : (VSYNC && le) ? vcnt + 4'd1 : vcnt;
        v_display_n      = video_clock_enable ? ((state_n == NORMAL) && (row_n < r6)) : v_display;
        v_total_n        = frame_end && !V_total;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= NORMAL;
            row            <= '0;
            ra             <= '0;
            adj            <= '0;
            vcnt           <= '0;
            row_start      <= '0;
            next_row_start <= '0;
            MA             <= '0;
            RA             <= '0;
            V_total        <= 1'b0;
            VSYNC          <= 1'b0;
            v_display      <= 1'b0;
        end else begin
            state          <= state_n;
            row            <= row_n;
            ra             <= ra_n;
            adj            <= adj_n;
            vcnt           <= vcnt_n;
            row_start      <= row_start_n;
            next_row_start <= next_row_start_n;
            MA             <= ma_n;
            RA             <= ra_out_n;
            V_total        <= v_total_n;
            VSYNC          <= vsync_n;
            v_display      <= v_display_n;
        end
    end
endmodule
